// File: rtl/sm3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm3_pkg
// Description : Shared SM3 configuration constants, message-sender FSM state
//               encoding and byte-lane helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sm3_pkg;

  // Core SM3 configuration constants
  localparam int SM3_DIGEST_W = 256;
  localparam int SM3_BLOCK_W  = 512;
  localparam int SM3_ROUNDS   = 64;

  // Message sender FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ZERO = 2'd2
  } sndr_state_t;

  // Bytes carried by one data word of width dw
  function automatic int bpw_of(input int dw);
    return dw / 8;
  endfunction

  // True when byte lane b (0 = MSB lane) is valid on a last beat with the
  // given tail; a tail of 0 means the last word is completely filled.
  function automatic logic tail_keep(input int b, input logic [2:0] tail);
    return (tail == 3'd0) || (b < int'(tail));
  endfunction

endpackage : sm3_pkg
`default_nettype wire

// File: rtl/sm3_beat_reg.sv
`default_nettype none
// ============================================================================
// Module      : sm3_beat_reg
// Description : Single-entry valid/ready pipeline register carrying a data
//               word, its byte-valid mask and a last flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sm3_beat_reg #(
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_d,
  input  logic [MW-1:0] i_mask,
  input  logic          i_lst,
  output logic          o_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_d,
  output logic [MW-1:0] o_mask,
  output logic          o_lst,
  input  logic          i_rdy
);

  logic          r_vld;
  logic [DW-1:0] r_d;
  logic [MW-1:0] r_mask;
  logic          r_lst;

  // Slot can take a new beat when empty or when the held beat leaves this cycle
  assign o_rdy = !r_vld || i_rdy;

  // Load a new beat when the slot frees up; payload is held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_d    <= '0;
      r_mask <= '0;
      r_lst  <= 1'b0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_d    <= i_d;
        r_mask <= i_mask;
        r_lst  <= i_lst;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_d    = r_d;
  assign o_mask = r_mask;
  assign o_lst  = r_lst;

endmodule : sm3_beat_reg
`default_nettype wire

// File: rtl/sm3_msg_sndr.sv
`default_nettype none
// ============================================================================
// Module      : sm3_msg_sndr
// Description : Converts a byte-length descriptor plus a stream of source
//               words into masked, last-flagged beats for the SM3 core input.
// Revision    : 1.0 - initial release
// ============================================================================
module sm3_msg_sndr
  import sm3_pkg::*;
#(
  parameter int INPT_DW = 32,   // 32 or 64
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  input  logic [LEN_W-1:0]     cmd_len_byte,
  output logic                 cmd_rdy,
  input  logic [INPT_DW-1:0]   src_d,
  input  logic                 src_vld,
  output logic                 src_rdy,
  output logic [INPT_DW-1:0]   msg_inpt_d,
  output logic [INPT_DW/8-1:0] msg_inpt_vld_byte,
  output logic                 msg_inpt_vld,
  output logic                 msg_inpt_lst,
  input  logic                 msg_inpt_rdy,
  output logic                 busy,
  output logic                 msg_done
);

  localparam int BPW = bpw_of(INPT_DW);
  localparam int TW  = $clog2(BPW);

  sndr_state_t        r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_rem;
  logic [TW-1:0]      r_tail;
  logic               r_done;

  logic               w_in_vld, w_in_rdy, w_in_lst;
  logic [INPT_DW-1:0] w_in_d, w_src_masked;
  logic [BPW-1:0]     w_in_mask, w_beat_mask;
  logic               w_cmd_rdy, w_src_rdy, w_cmd_acc, w_src_acc, w_last;
  logic [LEN_W-1:0]   w_nb;

  // Beat count is computed by shift-and-round-up so the maximum length cannot
  // overflow the LEN_W-bit counter.
  assign w_nb      = (cmd_len_byte >> TW) + LEN_W'(|cmd_len_byte[TW-1:0]);
  assign w_last    = (r_rem == LEN_W'(1));
  assign w_cmd_acc = cmd_vld && w_cmd_rdy;
  assign w_src_acc = src_vld && w_src_rdy;

  // Per-lane mask and data zeroing; only the last beat can be partial
  for (genvar gb = 0; gb < BPW; gb++) begin : g_byte
    assign w_beat_mask[BPW-1-gb] = !w_last || tail_keep(gb, 3'(r_tail));
    assign w_src_masked[INPT_DW-1-8*gb -: 8] =
      w_beat_mask[BPW-1-gb] ? src_d[INPT_DW-1-8*gb -: 8] : 8'h00;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_rdy   = 1'b0;
    w_src_rdy   = 1'b0;
    w_in_vld    = 1'b0;
    w_in_d      = '0;
    w_in_mask   = '0;
    w_in_lst    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_rdy = !msg_inpt_vld;
        if (cmd_vld && !msg_inpt_vld) begin
          w_state_nxt = (cmd_len_byte == '0) ? ST_ZERO : ST_SEND;
        end
      end
      ST_SEND: begin
        w_src_rdy = w_in_rdy && (r_rem != '0);
        w_in_vld  = src_vld && w_src_rdy;
        w_in_d    = w_src_masked;
        w_in_mask = w_beat_mask;
        w_in_lst  = w_last;
        if (w_in_vld && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ZERO: begin
        w_in_vld = 1'b1;
        w_in_lst = 1'b1;
        if (w_in_rdy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, beat counter, tail and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_tail  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= msg_inpt_vld && msg_inpt_rdy && msg_inpt_lst;
      if (w_cmd_acc) begin
        r_rem  <= w_nb;
        r_tail <= cmd_len_byte[TW-1:0];
      end else if (w_src_acc) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  sm3_beat_reg #(
    .DW (INPT_DW),
    .MW (BPW)
  ) u_beat_reg (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_in_vld),
    .i_d    (w_in_d),
    .i_mask (w_in_mask),
    .i_lst  (w_in_lst),
    .o_rdy  (w_in_rdy),
    .o_vld  (msg_inpt_vld),
    .o_d    (msg_inpt_d),
    .o_mask (msg_inpt_vld_byte),
    .o_lst  (msg_inpt_lst),
    .i_rdy  (msg_inpt_rdy)
  );

  assign cmd_rdy  = w_cmd_rdy;
  assign src_rdy  = w_src_rdy;
  assign busy     = (r_state != ST_IDLE) || msg_inpt_vld;
  assign msg_done = r_done;

endmodule : sm3_msg_sndr
`default_nettype wire
